ibex_fetch_req_ctrl: RTL and testbench

IBEX_FETCH_REQ_CTRL -- requirements
Module: ibex_fetch_req_ctrl

---
 rtl/ibex_fetch_req_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ibex_fetch_req_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_fetch_req_ctrl.sv
// rtl/ibex_fetch_req_ctrl.sv - instruction fetch bus request controller with in-order discard tracking
// Optional feature macro: IBEX_FETCH_DISCARD_CNT_EN (saturating discarded-response counter).
module ibex_fetch_req_ctrl #(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                instr_req_o,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_gnt_i,
  input  logic                instr_rvalid_i,
  output logic                fifo_valid_o,
  output logic                fifo_clear_o,
  output logic [31:0]         fifo_addr_o,
  output logic                busy_o,
  output logic [15:0]         discard_cnt_o
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [0:0] {
    IDLE,
    WAIT_GNT
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        fetch_addr_q, fetch_addr_d;
  logic               pend_q, pend_d;
  logic [31:0]        pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [NUM_REQS-1:0] disc_q, disc_d;

  logic [CNT_W-1:0]   busy_cnt;
  logic [CNT_W-1:0]   eff_busy;
  logic               issue;
  logic [31:0]        branch_tgt;
  logic               push_disc;
  logic               gnt_acc;
  logic [NUM_REQS-1:0] valid_mask;
  logic [NUM_REQS-1:0] disc_mark;
  logic [NUM_REQS-1:0] disc_pop;
  logic [CNT_W-1:0]   cnt_pop;

  assign branch_tgt = {addr_i[31:2], 2'b00};

  // FIFO entries still filling are ignored on a redirect since the FIFO is cleared in that cycle.
  always_comb begin
    busy_cnt = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      busy_cnt = busy_cnt + {{(CNT_W-1){1'b0}}, fifo_busy_i[i]};
    end
    eff_busy = branch_i ? '0 : busy_cnt;
    issue    = req_i && (({1'b0, out_cnt_q} + {1'b0, eff_busy}) < 4'(NUM_REQS));
  end

  always_comb begin
    state_d      = state_q;
    instr_req_o  = 1'b0;
    instr_addr_o = fetch_addr_q;
    fetch_addr_d = fetch_addr_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    push_disc    = 1'b0;
    case (state_q)
      IDLE: begin
        instr_req_o  = issue;
        instr_addr_o = branch_i ? branch_tgt : fetch_addr_q;
        if (issue && instr_gnt_i) begin
          fetch_addr_d = instr_addr_o + 32'd4;
        end else if (branch_i) begin
          fetch_addr_d = branch_tgt;
        end
        if (issue && !instr_gnt_i) begin
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        // The address on the bus is frozen; redirects are parked until the grant.
        instr_req_o  = 1'b1;
        instr_addr_o = fetch_addr_q;
        if (instr_gnt_i) begin
          state_d   = IDLE;
          push_disc = pend_q | branch_i;
          pend_d    = 1'b0;
          if (branch_i) begin
            fetch_addr_d = branch_tgt;
          end else if (pend_q) begin
            fetch_addr_d = pend_addr_q;
          end else begin
            fetch_addr_d = fetch_addr_q + 32'd4;
          end
        end else if (branch_i) begin
          pend_d      = 1'b1;
          pend_addr_d = branch_tgt;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign gnt_acc = instr_req_o & instr_gnt_i;

  // Discard flags: bit 0 is the oldest granted request; a redirect poisons every live entry.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      valid_mask[i] = (CNT_W'(i) < out_cnt_q);
    end
    disc_mark = branch_i ? (disc_q | valid_mask) : disc_q;
    disc_pop  = instr_rvalid_i ? (disc_mark >> 1) : disc_mark;
    cnt_pop   = out_cnt_q - {{(CNT_W-1){1'b0}}, instr_rvalid_i};
    disc_d    = disc_pop;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      if (gnt_acc && (cnt_pop == CNT_W'(i))) begin
        disc_d[i] = push_disc;
      end
    end
    out_cnt_d = out_cnt_q + {{(CNT_W-1){1'b0}}, gnt_acc} - {{(CNT_W-1){1'b0}}, instr_rvalid_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      pend_q       <= 1'b0;
      pend_addr_q  <= '0;
      out_cnt_q    <= '0;
      disc_q       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      pend_q       <= pend_d;
      pend_addr_q  <= pend_addr_d;
      out_cnt_q    <= out_cnt_d;
      disc_q       <= disc_d;
    end
  end

  assign fifo_valid_o = instr_rvalid_i & ~disc_q[0] & ~branch_i;
  assign fifo_clear_o = branch_i;
  assign fifo_addr_o  = addr_i;
  assign busy_o       = (out_cnt_q != '0) | instr_req_o;

`ifdef IBEX_FETCH_DISCARD_CNT_EN
  logic        discard_hit;
  logic [15:0] disc_cnt_q;

  assign discard_hit = instr_rvalid_i & (disc_q[0] | branch_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      disc_cnt_q <= '0;
    end else if (discard_hit && (disc_cnt_q != 16'hFFFF)) begin
      disc_cnt_q <= disc_cnt_q + 16'd1;
    end
  end

  assign discard_cnt_o = disc_cnt_q;
`else
  assign discard_cnt_o = '0;
`endif

  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) instr_rvalid_i |-> (out_cnt_q != '0)
  );

  outstanding_bounded: assert property (
    @(posedge clk_i) disable iff (rst_i) out_cnt_q <= CNT_W'(NUM_REQS)
  );

endmodule

// File: tb/tb_ibex_fetch_req_ctrl.sv
// tb/tb_ibex_fetch_req_ctrl.sv - directed self-checking bench for ibex_fetch_req_ctrl
module tb_ibex_fetch_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic [1:0]  fifo_busy_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic        fifo_valid_o;
  logic        fifo_clear_o;
  logic [31:0] fifo_addr_o;
  logic        busy_o;
  logic [15:0] discard_cnt_o;

  int total = 0;
  int bad   = 0;

`ifdef IBEX_FETCH_DISCARD_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_i          (req_i),
    .branch_i       (branch_i),
    .addr_i         (addr_i),
    .fifo_busy_i    (fifo_busy_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .fifo_valid_o   (fifo_valid_o),
    .fifo_clear_o   (fifo_clear_o),
    .fifo_addr_o    (fifo_addr_o),
    .busy_o         (busy_o),
    .discard_cnt_o  (discard_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs;
    req_i = 0; branch_i = 0; addr_i = '0; fifo_busy_i = '0;
    instr_gnt_i = 0; instr_rvalid_i = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_i = 1;
    tick(); tick();
    rst_i = 0;
    #1;
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", instr_req_o); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (fifo_valid_o !== 1'b0 || fifo_clear_o !== 1'b0) begin bad++; $display("FAIL reset_fifo got=%b%b exp=00", fifo_valid_o, fifo_clear_o); end
    total++; if (discard_cnt_o !== 16'd0) begin bad++; $display("FAIL reset_dcnt got=%0d exp=0", discard_cnt_o); end
    total++; if (instr_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", instr_addr_o); end
  endtask

  task automatic test_sequential;
    for (int k = 0; k < 4; k++) begin
      req_i = 1; instr_gnt_i = 1; instr_rvalid_i = (k > 0);
      #1;
      total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL seq_req[%0d] got=%b exp=1", k, instr_req_o); end
      total++; if (instr_addr_o !== 32'(4 * k)) begin bad++; $display("FAIL seq_addr[%0d] got=%h exp=%h", k, instr_addr_o, 32'(4 * k)); end
      total++; if (fifo_valid_o !== (k > 0)) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=%b", k, fifo_valid_o, (k > 0)); end
      tick();
    end
    req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1;
    #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL seq_last_valid got=%b exp=1", fifo_valid_o); end
    tick();
    instr_rvalid_i = 0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL seq_drained_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_gnt_stall;
    for (int k = 0; k < 5; k++) begin
      req_i = (k == 0) ? 1'b1 : 1'(k % 2);
      fifo_busy_i = (k == 0) ? 2'b00 : 2'b11;
      instr_gnt_i = 0;
      #1;
      total++; if (instr_req_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL stall_req[%0d] got=%b%b exp=11", k, instr_req_o, busy_o); end
      total++; if (instr_addr_o !== 32'h10) begin bad++; $display("FAIL stall_addr[%0d] got=%h exp=00000010", k, instr_addr_o); end
      tick();
    end
    req_i = 1; fifo_busy_i = 2'b00; instr_gnt_i = 1;
    #1;
    total++; if (instr_addr_o !== 32'h10) begin bad++; $display("FAIL stall_gnt_addr got=%h exp=00000010", instr_addr_o); end
    tick();
  endtask

  task automatic test_branch_outstanding;
    req_i = 1; instr_gnt_i = 1;
    #1;
    total++; if (instr_addr_o !== 32'h14) begin bad++; $display("FAIL bro_second_addr got=%h exp=00000014", instr_addr_o); end
    tick();
    instr_gnt_i = 0; branch_i = 1; addr_i = 32'h1002;
    #1;
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL bro_limit_req got=%b exp=0", instr_req_o); end
    total++; if (fifo_clear_o !== 1'b1 || fifo_addr_o !== 32'h1002) begin bad++; $display("FAIL bro_clear got=%b/%h exp=1/00001002", fifo_clear_o, fifo_addr_o); end
    tick();
    branch_i = 0; req_i = 0; instr_rvalid_i = 1;
    #1;
    total++; if (fifo_clear_o !== 1'b0) begin bad++; $display("FAIL bro_clear_pulse got=%b exp=0", fifo_clear_o); end
    total++; if (fifo_valid_o !== 1'b0) begin bad++; $display("FAIL bro_rv1 got=%b exp=0", fifo_valid_o); end
    tick();
    #1;
    total++; if (fifo_valid_o !== 1'b0) begin bad++; $display("FAIL bro_rv2 got=%b exp=0", fifo_valid_o); end
    tick();
    instr_rvalid_i = 0;
    #1;
    total++; if (discard_cnt_o !== (CNT_ON ? 16'd2 : 16'd0)) begin bad++; $display("FAIL bro_dcnt got=%0d exp=%0d", discard_cnt_o, CNT_ON ? 2 : 0); end
    req_i = 1; instr_gnt_i = 1;
    #1;
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h1000) begin bad++; $display("FAIL bro_target got=%b/%h exp=1/00001000", instr_req_o, instr_addr_o); end
    tick();
    req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1;
    #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL bro_target_valid got=%b exp=1", fifo_valid_o); end
    tick();
    instr_rvalid_i = 0;
  endtask

  task automatic test_branch_wait_gnt;
    branch_i = 1; addr_i = 32'h40;
    tick();
    branch_i = 0; req_i = 1;
    tick();
    branch_i = 1; addr_i = 32'h200; req_i = 0;
    #1;
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h40) begin bad++; $display("FAIL bwg_hold got=%b/%h exp=1/00000040", instr_req_o, instr_addr_o); end
    total++; if (fifo_clear_o !== 1'b1 || fifo_addr_o !== 32'h200) begin bad++; $display("FAIL bwg_clear got=%b/%h exp=1/00000200", fifo_clear_o, fifo_addr_o); end
    tick();
    branch_i = 0; instr_gnt_i = 1;
    #1;
    total++; if (instr_addr_o !== 32'h40) begin bad++; $display("FAIL bwg_gnt_addr got=%h exp=00000040", instr_addr_o); end
    tick();
    instr_gnt_i = 0; req_i = 1; instr_rvalid_i = 1;
    #1;
    total++; if (fifo_valid_o !== 1'b0) begin bad++; $display("FAIL bwg_discard got=%b exp=0", fifo_valid_o); end
    total++; if (instr_addr_o !== 32'h200) begin bad++; $display("FAIL bwg_next_addr got=%h exp=00000200", instr_addr_o); end
    tick();
    instr_rvalid_i = 0; instr_gnt_i = 1;
    tick();
    req_i = 0; instr_gnt_i = 0; instr_rvalid_i = 1;
    #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL bwg_target_valid got=%b exp=1", fifo_valid_o); end
    tick();
    instr_rvalid_i = 0;
    #1;
    total++; if (discard_cnt_o !== (CNT_ON ? 16'd3 : 16'd0)) begin bad++; $display("FAIL bwg_dcnt got=%0d exp=%0d", discard_cnt_o, CNT_ON ? 3 : 0); end
  endtask

  task automatic test_back_to_back;
    req_i = 1;
    tick();
    req_i = 0; branch_i = 1; addr_i = 32'h500;
    tick();
    addr_i = 32'h604;
    tick();
    branch_i = 0; instr_gnt_i = 1;
    #1;
    total++; if (instr_addr_o !== 32'h204) begin bad++; $display("FAIL b2b_hold got=%h exp=00000204", instr_addr_o); end
    tick();
    req_i = 1; instr_rvalid_i = 1;
    #1;
    total++; if (instr_addr_o !== 32'h604) begin bad++; $display("FAIL b2b_latest got=%h exp=00000604", instr_addr_o); end
    total++; if (fifo_valid_o !== 1'b0) begin bad++; $display("FAIL b2b_discard got=%b exp=0", fifo_valid_o); end
    tick();
    req_i = 0; instr_gnt_i = 0;
    #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", fifo_valid_o); end
    tick();
    instr_rvalid_i = 0;
    #1;
    total++; if (discard_cnt_o !== (CNT_ON ? 16'd4 : 16'd0)) begin bad++; $display("FAIL b2b_dcnt got=%0d exp=%0d", discard_cnt_o, CNT_ON ? 4 : 0); end
  endtask

  task automatic test_fifo_busy;
    req_i = 1; fifo_busy_i = 2'b11;
    #1;
    total++; if (instr_req_o !== 1'b0) begin bad++; $display("FAIL fb_full_req got=%b exp=0", instr_req_o); end
    fifo_busy_i = 2'b01;
    #1;
    total++; if (instr_req_o !== 1'b1) begin bad++; $display("FAIL fb_one_req got=%b exp=1", instr_req_o); end
    fifo_busy_i = 2'b11;
    tick();
    branch_i = 1; addr_i = 32'h800; instr_gnt_i = 1;
    #1;
    total++; if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h800) begin bad++; $display("FAIL fb_branch_req got=%b/%h exp=1/00000800", instr_req_o, instr_addr_o); end
    tick();
    idle_inputs();
    instr_rvalid_i = 1;
    #1;
    total++; if (fifo_valid_o !== 1'b1) begin bad++; $display("FAIL fb_branch_valid got=%b exp=1", fifo_valid_o); end
    tick();
    instr_rvalid_i = 0;
  endtask

  task automatic test_wrap;
    req_i = 1; instr_gnt_i = 1; branch_i = 1; addr_i = 32'hFFFF_FFFC;
    #1;
    total++; if (instr_addr_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffc", instr_addr_o); end
    tick();
    branch_i = 0; instr_rvalid_i = 1;
    #1;
    total++; if (instr_addr_o !== 32'h0) begin bad++; $display("FAIL wrap_zero got=%h exp=00000000", instr_addr_o); end
    tick();
    req_i = 0; instr_gnt_i = 0;
    tick();
    instr_rvalid_i = 0;
  endtask

  task automatic test_reset_mid;
    req_i = 1; instr_gnt_i = 1;
    tick();
    req_i = 0; instr_gnt_i = 0; rst_i = 1;
    tick();
    rst_i = 0;
    #1;
    total++; if (busy_o !== 1'b0 || instr_addr_o !== 32'h0) begin bad++; $display("FAIL rstmid got=%b/%h exp=0/00000000", busy_o, instr_addr_o); end
    total++; if (discard_cnt_o !== 16'd0) begin bad++; $display("FAIL rstmid_dcnt got=%0d exp=0", discard_cnt_o); end
  endtask

  initial begin
    rst_i = 1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_gnt_stall();
    test_branch_outstanding();
    test_branch_wait_gnt();
    test_back_to_back();
    test_fifo_busy();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
